des_iter_sched: RTL and testbench

- Iterative DES encryption scheduler. One shared key_schedule + round datapath is time-multiplexed over `N_R` cycles per block and shared between two requesters.
- Round-robin arbitration between requesters; valid/ready handshakes on both input channels and on the single output channel.
- Instantiates pre_processing, key_schedule, round and post_processing once each. It is the area-lean alternative to the fully pipelined encryptor and produces identical ciphertext.

---
 rtl/des_iter_sched.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_des_iter_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/des_iter_sched.sv
// ============================================================================
//  Module      : des_iter_sched (with des_pkg, pre_processing, key_schedule,
//                round, post_processing)
//  Description : Iterative DES encryptor. One key-schedule step and one
//                Feistel round are reused over 16 cycles per block, shared
//                round-robin between two requesters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef N_K
`define N_K 64
`endif
`ifndef N_B
`define N_B 64
`endif
`ifndef N_R
`define N_R 16
`endif

package des_pkg;
    // DES tables, 1-based, bit 1 is the MSB of the source word
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9,  1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27,  19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29,  21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5,  3,28,15,6,21,10,
                                  23,19,12,4,26,8,  16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int E_T [48] = '{32,1,2,3,4,5,     4,5,6,7,8,9,
                                8,9,10,11,12,13,  12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25,
                                24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    // Each S-box: rows 0..3 concatenated, 16 nibbles per row, entry 0 at the MSB
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
        return y;
    endfunction

    // Cipher function f(R, K): expand, key mix, S-box substitute, permute
    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  b;
        logic [5:0]  sel;
        for (int i = 0; i < 48; i++) e[6'(47 - i)] = r[5'(32 - E_T[6'(i)])];
        e = e ^ k;
        for (int j = 0; j < 8; j++) begin
            b   = e[6'(47 - 6 * j) -: 6];
            sel = {b[5], b[0], b[4:1]};     // row*16 + column
            s[5'(31 - 4 * j) -: 4] = SBOX[3'(j)][8'(255 - 4 * int'(sel)) -: 4];
        end
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[5'(i)])];
        return y;
    endfunction
endpackage

// Initial permutation of the block and PC-1 reduction of the key
module pre_processing (
    input  logic [63:0] k,
    input  logic [63:0] m,
    output logic [55:0] r,
    output logic [31:0] r0,
    output logic [31:0] r1
);
    logic [63:0] w_ip;
    assign r    = des_pkg::perm_pc1(k);
    assign w_ip = des_pkg::perm_ip(m);
    assign r1   = w_ip[63:32];
    assign r0   = w_ip[31:0];
endmodule

// One key-schedule step: rotate C and D halves, then PC-2 to a round key
module key_schedule (
    input  logic [3:0]  i,
    input  logic [55:0] x,
    output logic [55:0] r,
    output logic [47:0] k
);
    logic [27:0] w_c;
    logic [27:0] w_d;
    logic        w_single;

    // rounds 1, 2, 9 and 16 rotate by one place, all others by two
    always_comb begin
        w_single = (i == 4'd0) || (i == 4'd1) || (i == 4'd8) || (i == 4'd15);
        if (w_single) begin
            w_c = {x[54:28], x[55]};
            w_d = {x[26:0],  x[27]};
        end else begin
            w_c = {x[53:28], x[55:54]};
            w_d = {x[25:0],  x[27:26]};
        end
    end

    assign r = {w_c, w_d};
    assign k = des_pkg::perm_pc2({w_c, w_d});
endmodule

// One Feistel round: L' = R, R' = L ^ f(R, K)
module round (
    input  logic [31:0] xl,
    input  logic [31:0] xr,
    input  logic [47:0] k,
    output logic [31:0] rl,
    output logic [31:0] rr
);
    assign rl = xr;
    assign rr = xl ^ des_pkg::feistel(xr, k);
endmodule

// Undo the last half swap and apply the final permutation
module post_processing (
    input  logic [31:0] x0,
    input  logic [31:0] x1,
    output logic [63:0] c
);
    assign c = des_pkg::perm_fp({x1, x0});
endmodule

module des_iter_sched #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [`N_K-1:0]   k0,
    input  logic [`N_B-1:0]   m0,
    input  logic              in_valid0,
    output logic              in_ready0,
    input  logic [`N_K-1:0]   k1,
    input  logic [`N_B-1:0]   m1,
    input  logic              in_valid1,
    output logic              in_ready1,
    output logic [`N_B-1:0]   c,
    output logic              c_id,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  done_cnt
);
    localparam logic [3:0] LAST_RND = 4'(`N_R - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [55:0]        key_st_q, key_st_d;
    logic [63:0]        msg_st_q, msg_st_d;
    logic [3:0]         rnd_q, rnd_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic [`N_B-1:0]    c_q, c_d;
    logic               c_id_q, c_id_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;

    logic [63:0]        w_k_sel;
    logic [63:0]        w_m_sel;
    logic [55:0]        w_pre_r;
    logic [31:0]        w_pre_r0;
    logic [31:0]        w_pre_r1;
    logic [55:0]        w_ks_r;
    logic [47:0]        w_ks_k;
    logic [31:0]        w_rl;
    logic [31:0]        w_rr;
    logic [63:0]        w_post_c;

    // Round-robin grant, only while idle; last_q holds the previous winner
    assign in_ready0 = (state_q == IDLE) && in_valid0 && (!in_valid1 || last_q);
    assign in_ready1 = (state_q == IDLE) && in_valid1 && (!in_valid0 || !last_q);

    assign w_k_sel = in_ready1 ? k1 : k0;
    assign w_m_sel = in_ready1 ? m1 : m0;

    pre_processing u_pre (
        .k  (w_k_sel),
        .m  (w_m_sel),
        .r  (w_pre_r),
        .r0 (w_pre_r0),
        .r1 (w_pre_r1)
    );

    key_schedule u_ks (
        .i (rnd_q),
        .x (key_st_q),
        .r (w_ks_r),
        .k (w_ks_k)
    );

    round u_round (
        .xl (msg_st_q[63:32]),
        .xr (msg_st_q[31:0]),
        .k  (w_ks_k),
        .rl (w_rl),
        .rr (w_rr)
    );

    post_processing u_post (
        .x0 (w_rl),
        .x1 (w_rr),
        .c  (w_post_c)
    );

    // Next-state logic: accept in IDLE, iterate in ROUND, hand off in DONE
    always_comb begin
        state_d     = state_q;
        key_st_d    = key_st_q;
        msg_st_d    = msg_st_q;
        rnd_d       = rnd_q;
        owner_d     = owner_q;
        last_d      = last_q;
        c_d         = c_q;
        c_id_d      = c_id_q;
        out_valid_d = out_valid_q;
        done_cnt_d  = done_cnt_q;
        case (state_q)
            IDLE: begin
                if (in_ready0 || in_ready1) begin
                    key_st_d = w_pre_r;
                    msg_st_d = {w_pre_r1, w_pre_r0};
                    rnd_d    = 4'd0;
                    owner_d  = in_ready1;
                    last_d   = in_ready1;
                    state_d  = ROUND;
                end
            end
            ROUND: begin
                key_st_d = w_ks_r;
                msg_st_d = {w_rl, w_rr};
                rnd_d    = rnd_q + 4'd1;
                if (rnd_q == LAST_RND) begin
                    c_d         = w_post_c;
                    c_id_d      = owner_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops any job in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            key_st_q    <= '0;
            msg_st_q    <= '0;
            rnd_q       <= 4'd0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            c_q         <= '0;
            c_id_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            key_st_q    <= key_st_d;
            msg_st_q    <= msg_st_d;
            rnd_q       <= rnd_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            c_q         <= c_d;
            c_id_q      <= c_id_d;
            out_valid_q <= out_valid_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign c         = c_q;
    assign c_id      = c_id_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign done_cnt  = done_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_des_iter_sched.sv
// ============================================================================
//  Module      : tb_des_iter_sched
//  Description : Directed, table-driven bench for des_iter_sched using the
//                two classic DES known-answer vectors.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_des_iter_sched;
    localparam int          CNT_W = 16;
    localparam logic [63:0] KA = 64'h133457799BBCDFF1;
    localparam logic [63:0] MA = 64'h0123456789ABCDEF;
    localparam logic [63:0] CA = 64'h85E813540F0AB405;
    localparam logic [63:0] KB = 64'h0E329232EA6D0D73;
    localparam logic [63:0] MB = 64'h8787878787878787;
    localparam logic [63:0] CB = 64'h0000000000000000;

    typedef struct {
        logic        req;
        logic [63:0] k;
        logic [63:0] m;
        logic [63:0] exp_c;
        logic        scramble;
    } job_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [63:0]      k0 = '0, m0 = '0, k1 = '0, m1 = '0;
    logic             in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic             in_ready0, in_ready1;
    logic [63:0]      c;
    logic             c_id;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] done_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    des_iter_sched #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .k0        (k0),
        .m0        (m0),
        .in_valid0 (in_valid0),
        .in_ready0 (in_ready0),
        .k1        (k1),
        .m1        (m1),
        .in_valid1 (in_valid1),
        .in_ready1 (in_ready1),
        .c         (c),
        .c_id      (c_id),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one job, wait for its result, and complete the handshake
    task automatic run_job(input job_t j);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        if (j.req) begin
            k1 = j.k; m1 = j.m; in_valid1 = 1'b1;
        end else begin
            k0 = j.k; m0 = j.m; in_valid0 = 1'b1;
        end
        #1;
        check("accept_ready", {63'd0, (j.req ? in_ready1 : in_ready0)}, 64'd1);
        @(negedge clk);
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (j.scramble) begin
                m0 = ~m0; m1 = ~m1; k0 = ~k0; k1 = ~k1;
            end
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'd16);
        check("c", c, j.exp_c);
        check("c_id", {63'd0, c_id}, {63'd0, j.req});
        @(negedge clk);
        exp_cnt++;
        check("out_valid_drop", {63'd0, out_valid}, 64'd0);
        check("busy_after", {63'd0, busy}, 64'd0);
        check("done_cnt", {48'd0, done_cnt}, 64'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        job_t jobs[5];
        int   outs, grants, prev_acc, both;
        logic [63:0] hold_c;

        jobs[0] = '{req: 1'b0, k: KA, m: MA, exp_c: CA, scramble: 1'b0};
        jobs[1] = '{req: 1'b1, k: KB, m: MB, exp_c: CB, scramble: 1'b0};
        jobs[2] = '{req: 1'b0, k: KB, m: MB, exp_c: CB, scramble: 1'b0};
        jobs[3] = '{req: 1'b1, k: KA, m: MA, exp_c: CA, scramble: 1'b0};
        jobs[4] = '{req: 1'b0, k: KA, m: MA, exp_c: CA, scramble: 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_c", c, 64'd0);
        check("rst_c_id", {63'd0, c_id}, 64'd0);
        check("rst_done_cnt", {48'd0, done_cnt}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);

        // Table of single jobs (last entry scrambles operands during ROUND)
        for (int i = 0; i < 5; i++) run_job(jobs[i]);

        // Backpressure: hold out_ready low for 10 cycles in DONE
        @(negedge clk);
        out_ready = 1'b0;
        k0 = KB; m0 = MB; in_valid0 = 1'b1;
        @(negedge clk);
        k1 = KA; m1 = MA; in_valid1 = 1'b1;
        outs = 0;
        while (!out_valid && outs < 40) begin
            @(negedge clk);
            outs++;
        end
        check("bp_c", c, CB);
        hold_c = c;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_c_hold", c, hold_c);
            check("bp_busy_ready", {61'd0, busy, in_ready0, in_ready1}, 64'd4);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        end
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        check("bp_release_valid", {63'd0, out_valid}, 64'd0);
        check("bp_release_busy", {63'd0, busy}, 64'd0);
        check("bp_done_cnt", {48'd0, done_cnt}, 64'(exp_cnt));

        // Fairness: both requesters continuously valid after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        k0 = KA; m0 = MA; k1 = KB; m1 = MB;
        in_valid0 = 1'b1; in_valid1 = 1'b1; out_ready = 1'b1;
        outs = 0; grants = 0; prev_acc = -1; both = 0;
        for (int cyc = 0; cyc < 300 && outs < 4; cyc++) begin
            #1;
            if (in_ready0 && in_ready1) both = 1;
            if (in_ready0 || in_ready1) begin
                check("fair_grant", {63'd0, in_ready1}, 64'(grants % 2));
                if (prev_acc >= 0) check("fair_gap", 64'(cyc - prev_acc), 64'd18);
                prev_acc = cyc;
                grants++;
            end
            if (out_valid) begin
                check("fair_c_id", {63'd0, c_id}, 64'(outs % 2));
                check("fair_c", c, (outs % 2 == 1) ? CB : CA);
                outs++;
            end
            @(negedge clk);
        end
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        check("fair_outputs", 64'(outs), 64'd4);
        check("fair_never_both", 64'(both), 64'd0);
        @(negedge clk);
        check("fair_done_cnt", {48'd0, done_cnt}, 64'd4);

        // Reset mid-ROUND at edge E8
        @(negedge clk);
        k0 = KA; m0 = MA; in_valid0 = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_done_cnt", {48'd0, done_cnt}, 64'd0);
        check("mid_rst_c", c, 64'd0);
        rst = 1'b0;
        exp_cnt = 0;
        run_job(jobs[0]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
